// File: rtl/rv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rv_encoder
// Description : Pipelined RV64IM instruction encoder. Packs a decoded
//               instruction into its 32-bit machine word, range-checks every
//               field and queues the results in order behind valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_encoder #(
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_class,
    input  logic [4:0]  in_sub,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [63:0] in_imm,
    input  logic [63:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    output logic        out_err,
    output logic [15:0] err_count
);

    localparam int              CW      = $clog2(QDEPTH + 3);
    localparam int              PW      = $clog2(QDEPTH);
    localparam logic [CW-1:0]   c_DEPTH = CW'(QDEPTH);
    localparam logic [PW-1:0]   c_LAST  = PW'(QDEPTH - 1);
    localparam logic [31:0]     c_NOP   = 32'h0000_0013;

    localparam logic [3:0] c_CL_OP     = 4'd0;
    localparam logic [3:0] c_CL_OPIMM  = 4'd1;
    localparam logic [3:0] c_CL_LOAD   = 4'd2;
    localparam logic [3:0] c_CL_STORE  = 4'd3;
    localparam logic [3:0] c_CL_BRANCH = 4'd4;
    localparam logic [3:0] c_CL_OP32   = 4'd5;
    localparam logic [3:0] c_CL_OPIMM32= 4'd6;
    localparam logic [3:0] c_CL_LUI    = 4'd7;
    localparam logic [3:0] c_CL_AUIPC  = 4'd8;
    localparam logic [3:0] c_CL_JAL    = 4'd9;
    localparam logic [3:0] c_CL_JALR   = 4'd10;
    localparam logic [3:0] c_CL_SYSTEM = 4'd11;

    // ------------------------------------------------------------------
    // Credit-based acceptance: every word in flight already owns a slot
    // ------------------------------------------------------------------
    logic          r_s1_v;
    logic          r_s2_v;
    logic [CW-1:0] r_q_count;
    logic [CW-1:0] w_used;
    logic          w_accept;
    logic          w_pop;

    assign w_used    = CW'(r_s1_v) + CW'(r_s2_v) + r_q_count;
    assign in_ready  = (w_used < c_DEPTH);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_q_count != '0);
    assign w_pop     = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Stage 1: register fields, resolve pc-relative offsets
    // ------------------------------------------------------------------
    logic [3:0]  r_s1_class;
    logic [4:0]  r_s1_sub;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs1;
    logic [4:0]  r_s1_rs2;
    logic [63:0] r_s1_off;
    logic [63:0] r_s1_pc;
    logic [63:0] w_off_in;

    assign w_off_in = ((in_class == c_CL_BRANCH) || (in_class == c_CL_JAL)) ?
                      (in_imm - in_pc) : in_imm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_v     <= 1'b0;
            r_s1_class <= '0;
            r_s1_sub   <= '0;
            r_s1_rd    <= '0;
            r_s1_rs1   <= '0;
            r_s1_rs2   <= '0;
            r_s1_off   <= '0;
            r_s1_pc    <= '0;
        end else begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_class <= in_class;
                r_s1_sub   <= in_sub;
                r_s1_rd    <= in_rd;
                r_s1_rs1   <= in_rs1;
                r_s1_rs2   <= in_rs2;
                r_s1_off   <= w_off_in;
                r_s1_pc    <= in_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 encode: opcode select, layout packing, legality checks
    // ------------------------------------------------------------------
    logic [2:0]  w_f3;
    logic        w_s12;
    logic        w_s13;
    logic        w_s21;
    logic        w_shift;
    logic        w_ok;
    logic [31:0] w_raw;

    always_comb begin
        w_f3    = r_s1_sub[2:0];
        w_s12   = (r_s1_off[63:11] == '0) || (r_s1_off[63:11] == '1);
        w_s13   = (r_s1_off[63:12] == '0) || (r_s1_off[63:12] == '1);
        w_s21   = (r_s1_off[63:20] == '0) || (r_s1_off[63:20] == '1);
        w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
        w_ok    = 1'b0;
        w_raw   = c_NOP;
        case (r_s1_class)
            c_CL_OP, c_CL_OP32: begin
                w_raw = {1'b0, r_s1_sub[4], 4'b0000, r_s1_sub[3], r_s1_rs2, r_s1_rs1,
                         w_f3, r_s1_rd, (r_s1_class == c_CL_OP) ? 7'h33 : 7'h3B};
                if (r_s1_class == c_CL_OP)
                    w_ok = (r_s1_sub[4:3] == 2'b00) || (r_s1_sub[4:3] == 2'b01) ||
                           (r_s1_sub == 5'b10000) || (r_s1_sub == 5'b10101);
                else
                    w_ok = (r_s1_sub == 5'b00000) || (r_s1_sub == 5'b00001) ||
                           (r_s1_sub == 5'b00101) || (r_s1_sub == 5'b10000) ||
                           (r_s1_sub == 5'b10101) || (r_s1_sub == 5'b01000) ||
                           (r_s1_sub[4:2] == 3'b011);
            end
            c_CL_OPIMM: begin
                if (w_shift) begin
                    w_raw = {1'b0, r_s1_sub[4], 4'b0000, r_s1_off[5:0], r_s1_rs1,
                             w_f3, r_s1_rd, 7'h13};
                    w_ok  = (r_s1_off[63:6] == '0);
                end else begin
                    w_raw = {r_s1_off[11:0], r_s1_rs1, w_f3, r_s1_rd, 7'h13};
                    w_ok  = w_s12;
                end
                w_ok = w_ok && !r_s1_sub[3] && (!r_s1_sub[4] || (w_f3 == 3'b101));
            end
            c_CL_OPIMM32: begin
                if (w_shift) begin
                    w_raw = {1'b0, r_s1_sub[4], 5'b00000, r_s1_off[4:0], r_s1_rs1,
                             w_f3, r_s1_rd, 7'h1B};
                    w_ok  = (r_s1_off[63:5] == '0) &&
                            ((r_s1_sub == 5'b00001) || (r_s1_sub == 5'b00101) ||
                             (r_s1_sub == 5'b10101));
                end else begin
                    w_raw = {r_s1_off[11:0], r_s1_rs1, w_f3, r_s1_rd, 7'h1B};
                    w_ok  = w_s12 && !r_s1_sub[4] && (w_f3 == 3'b000);
                end
            end
            c_CL_LOAD, c_CL_JALR: begin
                w_raw = {r_s1_off[11:0], r_s1_rs1, w_f3, r_s1_rd,
                         (r_s1_class == c_CL_LOAD) ? 7'h03 : 7'h67};
                w_ok  = w_s12 && ((r_s1_class == c_CL_LOAD) ? (w_f3 != 3'b111)
                                                           : (w_f3 == 3'b000));
            end
            c_CL_STORE: begin
                w_raw = {r_s1_off[11:5], r_s1_rs2, r_s1_rs1, w_f3, r_s1_off[4:0], 7'h23};
                w_ok  = w_s12 && !w_f3[2];
            end
            c_CL_BRANCH: begin
                w_raw = {r_s1_off[12], r_s1_off[10:5], r_s1_rs2, r_s1_rs1, w_f3,
                         r_s1_off[4:1], r_s1_off[11], 7'h63};
                w_ok  = w_s13 && !r_s1_off[0] && (w_f3[2:1] != 2'b01);
            end
            c_CL_LUI, c_CL_AUIPC: begin
                w_raw = {r_s1_off[19:0], r_s1_rd, (r_s1_class == c_CL_LUI) ? 7'h37 : 7'h17};
                w_ok  = (r_s1_off[63:20] == '0);
            end
            c_CL_JAL: begin
                w_raw = {r_s1_off[20], r_s1_off[10:1], r_s1_off[11], r_s1_off[19:12],
                         r_s1_rd, 7'h6F};
                w_ok  = w_s21 && !r_s1_off[0];
            end
            c_CL_SYSTEM: begin
                // rs1 slot carries either the source register or the 5-bit uimm
                w_raw = {r_s1_off[11:0], r_s1_rs1, w_f3, r_s1_rd, 7'h73};
                w_ok  = (r_s1_off[63:12] == '0) && (w_f3[1:0] != 2'b00);
            end
            default: begin
                w_ok  = 1'b0;
                w_raw = c_NOP;
            end
        endcase
    end

    logic [31:0] r_s2_inst;
    logic [63:0] r_s2_pc;
    logic        r_s2_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_v    <= 1'b0;
            r_s2_inst <= '0;
            r_s2_pc   <= '0;
            r_s2_err  <= 1'b0;
        end else begin
            r_s2_v    <= r_s1_v;
            r_s2_inst <= w_ok ? w_raw : c_NOP;
            r_s2_pc   <= r_s1_pc;
            r_s2_err  <= !w_ok;
        end
    end

    // ------------------------------------------------------------------
    // Output queue
    // ------------------------------------------------------------------
    logic [31:0]   r_q_inst [QDEPTH];
    logic [63:0]   r_q_pc   [QDEPTH];
    logic          r_q_err  [QDEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_hold_inst;
    logic [63:0]   r_hold_pc;
    logic [15:0]   r_err_count;

    always_ff @(posedge clk) begin
        if (r_s2_v) begin
            r_q_inst[r_wr_ptr] <= r_s2_inst;
            r_q_pc[r_wr_ptr]   <= r_s2_pc;
            r_q_err[r_wr_ptr]  <= r_s2_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_q_count   <= '0;
            r_hold_inst <= '0;
            r_hold_pc   <= '0;
            r_err_count <= '0;
        end else begin
            if (r_s2_v)
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            case ({r_s2_v, w_pop})
                2'b10:   r_q_count <= r_q_count + 1'b1;
                2'b01:   r_q_count <= r_q_count - 1'b1;
                default: r_q_count <= r_q_count;
            endcase
            // Remember the head so the output stays put once the queue drains
            if (out_valid) begin
                r_hold_inst <= r_q_inst[r_rd_ptr];
                r_hold_pc   <= r_q_pc[r_rd_ptr];
            end
            if (r_s2_v && r_s2_err && (r_err_count != 16'hFFFF))
                r_err_count <= r_err_count + 1'b1;
        end
    end

    assign out_inst  = out_valid ? r_q_inst[r_rd_ptr] : r_hold_inst;
    assign out_pc    = out_valid ? r_q_pc[r_rd_ptr]   : r_hold_pc;
    assign out_err   = out_valid && r_q_err[r_rd_ptr];
    assign err_count = r_err_count;

endmodule
`default_nettype wire
